// File: rtl/ws2812_write_arbiter_pkg.sv
// Shared types and constants for the ws2812 write path.
// The dim helper is used only when WS2812_ARB_DIM_EN is defined.
package ws2812_write_arbiter_pkg;

   localparam int RGB_W     = 24;
   localparam int CH_W      = 8;
   localparam int IDX_W_DEF = 8;
   localparam int N_REQ_DEF = 4;
   localparam int G_OFF     = 16;
   localparam int R_OFF     = 8;
   localparam int B_OFF     = 0;

   typedef struct packed {
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] b;
   } rgb_t;

   // (ch * (lvl + 1)) >> 8; lvl = 255 is identity
   function automatic logic [CH_W-1:0] dim_ch(
      input logic [CH_W-1:0] ch,
      input logic [CH_W-1:0] lvl
   );
      logic [16:0] p;
      p = {9'd0, ch} * ({9'd0, lvl} + 17'd1);
      return p[15:8];
   endfunction

endpackage

// File: rtl/ws2812_write_arbiter_if.sv
// Requester bundle: per-requester valid/ready plus packed LED index and colour.
// master = requesters, slave = arbiter.
interface ws2812_write_arbiter_if
   import ws2812_write_arbiter_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int IDX_W = IDX_W_DEF
);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*IDX_W-1:0] req_led_num;
   logic [N_REQ*RGB_W-1:0] req_rgb;

   modport master (
      output req_valid,
      output req_led_num,
      output req_rgb,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_led_num,
      input  req_rgb,
      output req_ready
   );

endinterface

// File: rtl/ws2812_write_arbiter_rr_arbiter.sv
// Round-robin picker: first request at or above i_ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module ws2812_write_arbiter_rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_ptr,
   output logic [N-1:0]         o_gnt,
   output logic [$clog2(N)-1:0] o_idx,
   output logic                 o_any
);

   localparam int PW = $clog2(N);

   always_comb begin
      int j;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(i_ptr) + k;
         if (j >= N) j = j - N;
         if (!o_any && i_req[j]) begin
            o_any    = 1'b1;
            o_gnt[j] = 1'b1;
            o_idx    = PW'(j);
         end
      end
   end

endmodule

// File: rtl/ws2812_write_arbiter.sv
// Round-robin write arbiter in front of the ws2812 driver update port.
// Define WS2812_ARB_DIM_EN to scale every channel by (dim_level+1)/256.
module ws2812_write_arbiter
   import ws2812_write_arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int NUM_LEDS = 8,
   parameter int IDX_W    = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   ws2812_write_arbiter_if.slave    req_if,
   input  logic [CH_W-1:0]          dim_level,
   output logic [IDX_W-1:0]         led_num,
   output logic [RGB_W-1:0]         rgb_data,
   output logic                     write,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     drop
);

   localparam int          PW  = $clog2(N_REQ);
   localparam logic [31:0] LIM = NUM_LEDS;

   logic [PW-1:0]    r_rr_ptr;
   logic [IDX_W-1:0] r_led_num;
   rgb_t             r_rgb;
   logic             r_write;
   logic [PW-1:0]    r_grant_id;
   logic             r_drop;

   logic [N_REQ-1:0] w_gnt;
   logic [PW-1:0]    w_gnt_idx;
   logic             w_any;
   logic [PW-1:0]    w_next_ptr;
   logic [IDX_W-1:0] w_sel_led;
   rgb_t             w_sel_rgb;
   rgb_t             w_out_rgb;
   logic             w_in_range;

   ws2812_write_arbiter_rr_arbiter #(
      .N (N_REQ)
   ) u_rr (
      .i_req (req_if.req_valid),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_gnt_idx),
      .o_any (w_any)
   );

   // ready must drop immediately on async reset, not wait for a clock
   assign req_if.req_ready = reset_n ? w_gnt : '0;

   assign w_sel_led  = req_if.req_led_num[w_gnt_idx*IDX_W +: IDX_W];
   assign w_sel_rgb  = req_if.req_rgb[w_gnt_idx*RGB_W +: RGB_W];
   assign w_in_range = 32'(w_sel_led) < LIM;
   assign w_next_ptr = (w_gnt_idx == PW'(N_REQ - 1)) ?
                       '0 : w_gnt_idx + PW'(1);

`ifdef WS2812_ARB_DIM_EN
   assign w_out_rgb.g = dim_ch(w_sel_rgb.g, dim_level);
   assign w_out_rgb.r = dim_ch(w_sel_rgb.r, dim_level);
   assign w_out_rgb.b = dim_ch(w_sel_rgb.b, dim_level);
`else
   logic w_unused_dim;
   assign w_unused_dim = ^dim_level;
   assign w_out_rgb    = w_sel_rgb;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr   <= '0;
         r_led_num  <= '0;
         r_rgb      <= '0;
         r_write    <= 1'b0;
         r_grant_id <= '0;
         r_drop     <= 1'b0;
      end else begin
         r_write <= 1'b0;
         r_drop  <= 1'b0;
         if (w_any) begin
            r_rr_ptr   <= w_next_ptr;
            r_grant_id <= w_gnt_idx;
            // out-of-range index is consumed but never reaches the driver
            if (w_in_range) begin
               r_write   <= 1'b1;
               r_led_num <= w_sel_led;
               r_rgb     <= w_out_rgb;
            end else begin
               r_drop <= 1'b1;
            end
         end
      end
   end

   assign led_num  = r_led_num;
   assign rgb_data = r_rgb;
   assign write    = r_write;
   assign grant_id = r_grant_id;
   assign drop     = r_drop;

endmodule

// File: tb/tb_ws2812_write_arbiter.sv
// Randomised bench for ws2812_write_arbiter against a queue-free behavioural model.
// Honours WS2812_ARB_DIM_EN when computing expected colours.
module tb_ws2812_write_arbiter;

   localparam int N  = 4;
   localparam int NL = 8;
   localparam int IW = 8;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [7:0]     dim_level;
   logic [IW-1:0]  led_num;
   logic [23:0]    rgb_data;
   logic           write;
   logic [1:0]     grant_id;
   logic           drop;

   ws2812_write_arbiter_if #(.N_REQ(N), .IDX_W(IW)) rif ();

   ws2812_write_arbiter #(
      .N_REQ    (N),
      .NUM_LEDS (NL),
      .IDX_W    (IW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_if    (rif.slave),
      .dim_level (dim_level),
      .led_num   (led_num),
      .rgb_data  (rgb_data),
      .write     (write),
      .grant_id  (grant_id),
      .drop      (drop)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int          m_ptr;
   logic [7:0]  m_led;
   logic [23:0] m_rgb;
   logic        m_write;
   logic        m_drop;
   int          m_gid;
   int          last_g;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_led   = '0;
      m_rgb   = '0;
      m_write = 1'b0;
      m_drop  = 1'b0;
      m_gid   = 0;
   endtask

   function automatic int model_pick(input logic [N-1:0] v);
      for (int k = 0; k < N; k++)
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [23:0] model_scale(input logic [23:0] c,
                                               input logic [7:0] d);
      logic [23:0] o;
      o = c;
`ifdef WS2812_ARB_DIM_EN
      for (int s = 0; s < 3; s++)
         o[s*8 +: 8] = 8'((int'(c[s*8 +: 8]) * (int'(d) + 1)) / 256);
`endif
      return o;
   endfunction

   task automatic chk_outputs();
      chk("write", 32'(write), 32'(m_write));
      chk("drop", 32'(drop), 32'(m_drop));
      chk("led_num", 32'(led_num), 32'(m_led));
      chk("rgb_data", 32'(rgb_data), 32'(m_rgb));
      if (m_write) chk("grant_id", 32'(grant_id), 32'(m_gid));
   endtask

   // called at a negedge: drive, check ready, advance model, check outputs
   task automatic cycle(input logic [N-1:0] v, input logic [N*IW-1:0] l,
                        input logic [N*24-1:0] c);
      int g;
      logic [7:0] ld;
      rif.req_valid   = v;
      rif.req_led_num = l;
      rif.req_rgb     = c;
      #1;
      g = model_pick(v);
      chk("req_ready", 32'(rif.req_ready),
          (g >= 0) ? (32'd1 << g) : 32'd0);
      last_g  = g;
      m_write = 1'b0;
      m_drop  = 1'b0;
      if (g >= 0) begin
         m_ptr = (g + 1) % N;
         ld    = l[g*IW +: IW];
         if (int'(ld) < NL) begin
            m_write = 1'b1;
            m_led   = ld;
            m_rgb   = model_scale(c[g*24 +: 24], dim_level);
            m_gid   = g;
         end else begin
            m_drop = 1'b1;
         end
      end
      @(negedge clk);
      chk_outputs();
   endtask

   logic [N-1:0]    cur_v;
   logic [7:0]      cur_l [N];
   logic [23:0]     cur_c [N];
   int              wait_cnt [N];
   logic [N*IW-1:0] pl;
   logic [N*24-1:0] pc;

   initial begin
      reset_n         = 1'b0;
      dim_level       = 8'hFF;
      rif.req_valid   = '1;
      rif.req_led_num = '0;
      rif.req_rgb     = '1;
      model_reset();
      last_g = -1;

      // reset with all requesters valid
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(rif.req_ready), 32'd0);
      chk_outputs();
      chk("rst_gid", 32'(grant_id), 32'd0);
      reset_n = 1'b1;

      // continuous contention: 0,1,2,3,0,...
      for (int i = 0; i < 8; i++) begin
         pl = '0;
         pc = '0;
         for (int r = 0; r < N; r++) begin
            pl[r*IW +: IW] = 8'(i % NL);
            pc[r*24 +: 24] = 24'(32'h010203 * (r + 1) + i);
         end
         cycle('1, pl, pc);
         chk("rr_order", 32'(grant_id), 32'(i % N));
         chk("rr_write", 32'(write), 32'd1);
      end

      // single requester 2
      pl = '0;
      pc = '0;
      pl[2*IW +: IW] = 8'd3;
      pc[2*24 +: 24] = 24'h100000;
      cycle(4'b0100, pl, pc);
      chk("single_write", 32'(write), 32'd1);
      chk("single_led", 32'(led_num), 32'd3);
      chk("single_rgb", 32'(rgb_data), 32'h100000);
      chk("single_gid", 32'(grant_id), 32'd2);
      cycle(4'b0000, pl, pc);
      chk("single_idle", 32'(write), 32'd0);

      // out of range then last valid index
      pl = '0;
      pc = '0;
      pl[1*IW +: IW] = 8'd8;
      pc[1*24 +: 24] = 24'hABCDEF;
      cycle(4'b0010, pl, pc);
      chk("oor_drop", 32'(drop), 32'd1);
      chk("oor_write", 32'(write), 32'd0);
      chk("oor_hold_led", 32'(led_num), 32'd3);
      chk("oor_hold_rgb", 32'(rgb_data), 32'h100000);
      pl[1*IW +: IW] = 8'd7;
      cycle(4'b0010, pl, pc);
      chk("max_write", 32'(write), 32'd1);
      chk("max_led", 32'(led_num), 32'd7);
      chk("max_drop", 32'(drop), 32'd0);

      // dimming
      pl = '0;
      pc = '0;
      pl[0 +: IW] = 8'd5;
      pc[0 +: 24] = 24'hFF8002;
      dim_level = 8'h7F;
      cycle(4'b0001, pl, pc);
`ifdef WS2812_ARB_DIM_EN
      chk("dim_7f", 32'(rgb_data), 32'h7F4001);
`else
      chk("dim_7f", 32'(rgb_data), 32'hFF8002);
`endif
      dim_level = 8'hFF;
      cycle(4'b0001, pl, pc);
      chk("dim_ff", 32'(rgb_data), 32'hFF8002);

      // async reset between accept and the capturing edge
      pl = '0;
      pc = '0;
      pl[3*IW +: IW] = 8'd2;
      pc[3*24 +: 24] = 24'h123456;
      rif.req_valid   = 4'b1000;
      rif.req_led_num = pl;
      rif.req_rgb     = pc;
      #1;
      chk("mid_ready", 32'(rif.req_ready), 32'b1000);
      #1;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("mid_ready_rst", 32'(rif.req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("mid_write", 32'(write), 32'd0);
      chk("mid_led", 32'(led_num), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      cycle('1, '0, '1);
      chk("mid_ptr0", 32'(grant_id), 32'd0);

      // randomised traffic, requesters hold payload until accepted
      for (int r = 0; r < N; r++) begin
         cur_v[r]    = 1'b0;
         cur_l[r]    = '0;
         cur_c[r]    = '0;
         wait_cnt[r] = 0;
      end
      for (int t = 0; t < 400; t++) begin
         dim_level = 8'($urandom);
         for (int r = 0; r < N; r++) begin
            pl[r*IW +: IW] = cur_l[r];
            pc[r*24 +: 24] = cur_c[r];
         end
         cycle(cur_v, pl, pc);
         for (int r = 0; r < N; r++) begin
            if (cur_v[r] && last_g != r) begin
               wait_cnt[r]++;
            end else begin
               if (cur_v[r]) begin
                  checks++;
                  if (wait_cnt[r] > N - 1) begin
                     errors++;
                     $display("FAIL starve req%0d: waited %0d max %0d",
                              r, wait_cnt[r], N - 1);
                  end
               end
               cur_v[r]    = ($urandom_range(0, 9) < 6);
               cur_l[r]    = 8'($urandom_range(0, 9));
               cur_c[r]    = 24'($urandom);
               wait_cnt[r] = 0;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
